inst_field_fifo: RTL and testbench
==================================

INST_FIELD_FIFO -- requirements
Module: inst_field_fifo

Interface
REQ-001 Parameter DEPTH, default 4, is the FIFO entry count; the legal range is a power of two from 2 to 16.
REQ-002 Parameter DROP_NOP, default 1; when it is 1, entries with inst == 3'b000 are discarded at the write side.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert and active-low.
REQ-005 in_valid  input  1  the producer presents a field pair.
REQ-006 in_comp  input  6  comp field from the upstream decode stage.
REQ-007 in_inst  input  3  inst field from the upstream decode stage.
REQ-008 in_ready  output  1  the FIFO can accept a write this cycle.
REQ-009 out_valid  output  1  the head entry is valid.
REQ-010 out_comp  output  6  comp field of the head entry.
REQ-011 out_inst  output  3  inst field of the head entry.
REQ-012 out_ready  input  1  the consumer accepts the head entry.
REQ-013 count  output  $clog2(DEPTH)+1  number of stored entries.
REQ-014 overflow  output  1  sticky flag for a write attempted while full.
REQ-015 nop_drops  output  8  saturating count of discarded NOP entries.

Function
REQ-016 A push occurs on an edge where in_valid=1, in_ready=1, and the entry is not a discarded NOP.
REQ-017 A pop occurs on an edge where out_valid=1 and out_ready=1.
REQ-018 in_ready is 1 exactly when count < DEPTH; it is combinational from registered state only.
REQ-019 out_valid is 1 exactly when count != 0; out_comp and out_inst are the head entry (first-word fall-through), driven from storage with no combinational path from in_*.
REQ-020 Write-to-read latency is 1 cycle: an entry pushed at edge N shows as out_valid=1 after edge N.
REQ-021 When the FIFO is empty, a concurrent in_valid does not bypass to the output.
REQ-022 On a simultaneous push and pop, count does not change and both pointers advance.
REQ-023 When full, in_ready=0 and the write is refused even if a pop occurs in the same cycle; the freed slot becomes writable the next cycle.
REQ-024 Read and write pointers wrap modulo DEPTH; full and empty are told apart by count, never by pointer equality alone.
REQ-025 When empty, out_ready is ignored, count is not decremented, and the pointers do not move.
REQ-026 overflow is set to 1 on any edge with in_valid=1 and in_ready=0, including NOP entries, and stays set until reset.
REQ-027 With DROP_NOP=1, in_valid=1, in_inst=3'b000 and in_ready=1: the entry is not stored and nop_drops increments, saturating at 8'hFF.
REQ-028 With DROP_NOP=0, a NOP entry is stored like any other and nop_drops stays 0.
REQ-029 When out_valid=0, out_comp and out_inst hold their last value and carry no meaning.

Reset
REQ-030 Asserting rst_n=0 at once sets count=0, out_valid=0, in_ready=1, overflow=0, nop_drops=0, both pointers=0, out_comp=6'h00, out_inst=3'h0, regardless of clk.
REQ-031 A reset mid-operation discards all stored entries; no entry from before the reset appears after rst_n rises.
REQ-032 Storage array contents are not reset; only pointers and count define valid entries.
REQ-033 The first push is accepted on the first rising edge after rst_n=1 that meets REQ-016.

Verification
REQ-034 Reset, then push {inst=3'b101, comp=6'h2A} with out_ready=0 -> after 1 edge: out_valid=1, out_inst=3'b101, out_comp=6'h2A, count=1.
REQ-035 DEPTH=4: push 5 distinct entries back-to-back with out_ready=0 -> count=4, in_ready=0 after the 4th push, overflow=1 after the 5th edge; pop all four -> they come out in order, 5th entry absent.
REQ-036 Hold in_valid=1 and out_ready=1 continuously with incrementing comp values 1..10 -> one entry per cycle in order, count stays at 1 after the first edge, no loss.
REQ-037 Full FIFO, assert in_valid=1 and out_ready=1 on one edge -> pop occurs, push refused, count=3, overflow=1; next edge the push is accepted, count=4.
REQ-038 DROP_NOP=1: push inst=3'b000 three times, then inst=3'b011 -> nop_drops=3, count=1, head inst=3'b011.
REQ-039 Push 2 entries, drive rst_n=0 between clock edges for 3 ns -> out_valid=0 and count=0 at once; after release, out_valid stays 0 until a new push.

Source files
------------

// File: rtl/inst_field_fifo.sv
// inst_field_fifo: first-word fall-through FIFO of decoded {comp, inst} pairs
// with optional write-side NOP discard and sticky overflow.
module inst_field_fifo #(
  parameter int DEPTH    = 4,
  parameter int DROP_NOP = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [5:0]                 in_comp,
  input  logic [2:0]                 in_inst,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [5:0]                 out_comp,
  output logic [2:0]                 out_inst,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic [7:0]                 nop_drops
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [5:0]    comp_mem [DEPTH];
  logic [2:0]    inst_mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [CW-1:0] cnt;
  logic [5:0]    hold_comp;
  logic [2:0]    hold_inst;
  logic          is_nop;
  logic          push;
  logic          pop;
  logic          drop;

  assign is_nop    = (DROP_NOP != 0) && (in_inst == 3'b000);
  assign in_ready  = cnt < FULL;
  assign out_valid = cnt != '0;
  assign push      = in_valid & in_ready & ~is_nop;
  assign drop      = in_valid & in_ready & is_nop;
  assign pop       = out_valid & out_ready;
  assign count     = cnt;

  // Head is read straight from storage; the hold copy covers the empty case.
  assign out_comp = out_valid ? comp_mem[rptr] : hold_comp;
  assign out_inst = out_valid ? inst_mem[rptr] : hold_inst;

  always_ff @(posedge clk) begin
    if (push) begin
      comp_mem[wptr] <= in_comp;
      inst_mem[wptr] <= in_inst;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr      <= '0;
      rptr      <= '0;
      cnt       <= '0;
      overflow  <= 1'b0;
      nop_drops <= 8'h00;
      hold_comp <= 6'h00;
      hold_inst <= 3'h0;
    end else begin
      if (push)
        wptr <= wptr + PW'(1);
      if (pop)
        rptr <= rptr + PW'(1);
      unique case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
      if (in_valid && !in_ready)
        overflow <= 1'b1;
      if (drop && nop_drops != 8'hFF)
        nop_drops <= nop_drops + 8'h01;
      if (out_valid) begin
        hold_comp <= comp_mem[rptr];
        hold_inst <= inst_mem[rptr];
      end
    end
  end

endmodule

// File: tb/tb_inst_field_fifo.sv
// Scoreboard bench for inst_field_fifo: directed vectors, queue-based
// monitor on the output side, plus a DROP_NOP=0 instance for NOP storage.
module tb_inst_field_fifo;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [5:0] in_comp;
  logic [2:0] in_inst;
  logic       in_ready;
  logic       out_valid;
  logic [5:0] out_comp;
  logic [2:0] out_inst;
  logic       out_ready;
  logic [2:0] count;
  logic       overflow;
  logic [7:0] nop_drops;

  logic       in_ready0;
  logic       out_valid0;
  logic [5:0] out_comp0;
  logic [2:0] out_inst0;
  logic [2:0] count0;
  logic       overflow0;
  logic [7:0] nop_drops0;

  int errors = 0;
  int checks = 0;
  logic [8:0] exp_q[$];

  inst_field_fifo #(.DEPTH(4), .DROP_NOP(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_comp(in_comp), .in_inst(in_inst),
    .in_ready(in_ready),
    .out_valid(out_valid), .out_comp(out_comp), .out_inst(out_inst),
    .out_ready(out_ready),
    .count(count), .overflow(overflow), .nop_drops(nop_drops)
  );

  inst_field_fifo #(.DEPTH(4), .DROP_NOP(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_comp(in_comp), .in_inst(in_inst),
    .in_ready(in_ready0),
    .out_valid(out_valid0), .out_comp(out_comp0), .out_inst(out_inst0),
    .out_ready(out_ready),
    .count(count0), .overflow(overflow0), .nop_drops(nop_drops0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] i,
                       input logic [5:0] c, input logic accept);
    in_valid = v;
    in_inst  = i;
    in_comp  = c;
    if (accept)
      exp_q.push_back({i, c});
  endtask

  task automatic summary();
    $display("Result: errors=%0d of %0d checks", errors, checks);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_comp   = 6'h00;
    in_inst   = 3'h0;
    out_ready = 1'b0;
    fork
      forever begin
        @(negedge clk);
        if (rst_n && out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected: got %0h expected none",
                     {out_inst, out_comp});
          end else
            chk("sb_head", int'({out_inst, out_comp}),
                int'(exp_q.pop_front()));
        end
      end
      begin
        #3;
        chk("rst_count", int'(count), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_nop_drops", int'(nop_drops), 0);
        chk("rst_out_comp", int'(out_comp), 0);
        chk("rst_out_inst", int'(out_inst), 0);
        #9 rst_n = 1'b1;

        // single entry, 1-cycle latency
        drive(1'b1, 3'b101, 6'h2A, 1'b1);
        tick();
        drive(1'b0, 3'b0, 6'h0, 1'b0);
        chk("lat_valid", int'(out_valid), 1);
        chk("lat_inst", int'(out_inst), 5);
        chk("lat_comp", int'(out_comp), 'h2A);
        chk("lat_count", int'(count), 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("lat_drain", int'(count), 0);
        chk("empty_hold_comp", int'(out_comp), 'h2A);

        // overfill
        for (int i = 0; i < 5; i++) begin
          drive(1'b1, 3'b001, 6'(8'h10 + i), i < 4);
          tick();
          if (i == 3) begin
            chk("full_count", int'(count), 4);
            chk("full_in_ready", int'(in_ready), 0);
            chk("full_overflow_pre", int'(overflow), 0);
          end
        end
        drive(1'b0, 3'b0, 6'h0, 1'b0);
        chk("ovf_flag", int'(overflow), 1);
        chk("ovf_count", int'(count), 4);
        out_ready = 1'b1;
        repeat (4) tick();
        chk("ovf_drained", int'(count), 0);
        tick();
        out_ready = 1'b0;
        chk("empty_no_dec", int'(count), 0);
        chk("ovf_queue", exp_q.size(), 0);

        // full with concurrent pop: write refused this edge
        for (int i = 0; i < 4; i++) begin
          drive(1'b1, 3'b110, 6'(8'h20 + i), 1'b1);
          tick();
        end
        drive(1'b1, 3'b110, 6'h24, 1'b1);
        out_ready = 1'b1;
        tick();
        chk("fullpop_count", int'(count), 3);
        chk("fullpop_ovf", int'(overflow), 1);
        out_ready = 1'b0;
        tick();
        chk("fullpop_next", int'(count), 4);
        drive(1'b0, 3'b0, 6'h0, 1'b0);
        out_ready = 1'b1;
        repeat (4) tick();
        out_ready = 1'b0;
        chk("fullpop_drained", int'(count), 0);

        // streaming
        out_ready = 1'b1;
        for (int i = 1; i <= 10; i++) begin
          drive(1'b1, 3'b010, 6'(i), 1'b1);
          tick();
          chk("stream_count", int'(count), 1);
        end
        drive(1'b0, 3'b0, 6'h0, 1'b0);
        tick();
        out_ready = 1'b0;
        chk("stream_end", int'(count), 0);
        chk("stream_queue", exp_q.size(), 0);

        // reset clears overflow, then NOP dropping
        rst_n = 1'b0;
        #2;
        chk("rst2_ovf", int'(overflow), 0);
        rst_n = 1'b1;
        for (int i = 1; i <= 3; i++) begin
          drive(1'b1, 3'b000, 6'(i), 1'b0);
          tick();
        end
        drive(1'b1, 3'b011, 6'h3F, 1'b1);
        tick();
        drive(1'b0, 3'b0, 6'h0, 1'b0);
        chk("nop_drops", int'(nop_drops), 3);
        chk("nop_count", int'(count), 1);
        chk("nop_head", int'(out_inst), 3);
        chk("keep_count", int'(count0), 4);
        chk("keep_drops", int'(nop_drops0), 0);
        chk("keep_head", int'({out_inst0, out_comp0}), 'h001);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("nop_drained", int'(count), 0);

        // mid-operation reset discards contents
        drive(1'b1, 3'b100, 6'h31, 1'b0);
        tick();
        drive(1'b1, 3'b100, 6'h32, 1'b0);
        tick();
        drive(1'b0, 3'b0, 6'h0, 1'b0);
        chk("pre_rst_count", int'(count), 2);
        #2 rst_n = 1'b0;
        #1;
        chk("async_valid", int'(out_valid), 0);
        chk("async_count", int'(count), 0);
        chk("async_comp", int'(out_comp), 0);
        #2 rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (3) begin
          tick();
          chk("post_rst_valid", int'(out_valid), 0);
        end
        out_ready = 1'b0;
        drive(1'b1, 3'b111, 6'h3C, 1'b1);
        tick();
        drive(1'b0, 3'b0, 6'h0, 1'b0);
        chk("post_rst_push", int'(out_valid), 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("final_count", int'(count), 0);
        chk("final_queue", exp_q.size(), 0);
        summary();
        $finish;
      end
      begin
        #100000;
        checks++;
        errors++;
        $display("FAIL timeout: got running expected done");
        summary();
        $finish;
      end
    join_any
  end

endmodule
